probe_capture_unit: RTL
=======================

Name: probe_capture_unit

Overview:
- Active probe source that drives the probe-hook signal bundle for one probe point.
- Samples a 32-bit design signal under command control and buffers samples in a small FIFO.
- Presents buffered samples upstream on DATAUP/DATAVALID with an ACK pop handshake.
- Decodes CMDEN/CMD commands addressed to its PROBE_ID; CTIMER provides the periodic sample tick.

Parameters:
PROBE_ID, 16'h0001, probe number matched against CMD[18:3]
DEPTH, 8, FIFO entries, power of two, 2..64
AW, 3, log2(DEPTH)

Ports:
UCLK  in  1  clock, all logic rising-edge
URST  in  1  synchronous, active-high reset
PROBE_IN  in  32  observed design signal
PROBE_STB  in  1  sample strobe from design (event mode)
CMDEN  in  1  command valid, single-cycle
CMD  in  19  [18:3] probe number, [2:0] opcode
CTIMER  in  1  periodic tick (periodic mode)
ACK  in  1  consumer pops head word
DATAUP  out  32  FIFO head word
DATAVALID  out  1  FIFO non-empty
DELAY  out  1  FIFO full (back-pressure indicator)
OVF_COUNT  out  8  dropped-sample count, saturating
ARMED  out  1  state != IDLE

Behaviour:
- Reset: FIFO empty, state IDLE, mode EVENT, OVF_COUNT=0, DATAVALID=0, DELAY=0, DATAUP=0.
- Commands act only when CMDEN=1 and CMD[18:3]==PROBE_ID; otherwise ignored. Opcodes:
  - 0 NOP
  - 1 ENABLE -> CONT
  - 2 DISABLE -> IDLE
  - 3 ONESHOT -> SINGLE
  - 4 FLUSH: empty FIFO, OVF_COUNT=0, state unchanged
  - 5 MODE_EVENT
  - 6 MODE_PERIODIC
  - 7 reserved, no effect
- States:
  - IDLE: no capture.
  - CONT: capture every sample event.
  - SINGLE: capture the first sample event, then go to IDLE on the same edge. This applies even if the sample is dropped as overflow.
- Sample event: PROBE_STB=1 in EVENT mode, CTIMER=1 in PERIODIC mode; evaluated only when state is CONT or SINGLE.
- Command timing: a command takes effect at the next edge. A sample event in the command cycle uses the pre-command state and mode.
- Capture: PROBE_IN is written into the FIFO tail on the event edge.
- Latency: a sample into an empty FIFO shows DATAVALID=1 and DATAUP=sample one cycle after the event cycle.
- Handshake:
  - ACK with DATAVALID=1 pops the head at the edge; the next word (or DATAVALID=0) appears the following cycle.
  - ACK with DATAVALID=0 is ignored.
  - DATAUP holds its value until popped.
  - DATAUP=0 whenever the FIFO is empty.
- Full, no ACK: the sample is dropped and OVF_COUNT increments, saturating at 255.
- Full with ACK in the same cycle: push and pop both occur; no drop; count unchanged.
- Empty with event in the same cycle: push only; ACK is ignored.
- FLUSH concurrent with an event or ACK: flush wins. FIFO ends empty, OVF_COUNT=0, and the event's sample is discarded (no count).
- DELAY=1 iff occupancy==DEPTH, registered with the FIFO state.
- Pointers: AW-bit wrap-around pointers plus an (AW+1)-bit occupancy counter.
- URST mid-operation: returns everything to reset values at the next edge; in-flight data is lost.

Test Plan:
- Reset, ENABLE (CMD={16'h0001,3'd1}), PROBE_STB with PROBE_IN=32'hA5A5_0001 -> DATAVALID=1, DATAUP=A5A5_0001 the next cycle; ACK -> DATAVALID=0 the cycle after.
- CMD with probe number 16'h0002 and ENABLE -> ignored; subsequent PROBE_STB produces no data; ARMED=0.
- CONT mode, 10 strobes (values 1..10) with no ACK, DEPTH=8 -> DELAY=1, OVF_COUNT=2; the ACK drain returns 1..8 in order.
- FIFO full, strobe and ACK in the same cycle -> OVF_COUNT unchanged, occupancy stays 8, new value is at the tail.
- ONESHOT, then 3 strobes (values 7, 8, 9) -> only 7 captured, ARMED=0 after the first strobe.
- MODE_PERIODIC + ENABLE, CTIMER pulses every 4 cycles with PROBE_STB toggling -> one word per CTIMER pulse. Then FLUSH together with ACK -> DATAVALID=0, OVF_COUNT=0 the next cycle.

Source files
------------

// File: rtl/probe_capture_unit.sv
// rtl/probe_capture_unit.sv - command-driven probe sampler with FIFO upstream port
module probe_capture_unit #(
  parameter logic [15:0] PROBE_ID = 16'h0001,
  parameter int          DEPTH    = 8,
  parameter int          AW       = 3
) (
  input  logic        i_uclk,
  input  logic        i_urst,
  input  logic [31:0] i_probe_in,
  input  logic        i_probe_stb,
  input  logic        i_cmden,
  input  logic [18:0] i_cmd,
  input  logic        i_ctimer,
  input  logic        i_ack,
  output logic [31:0] o_dataup,
  output logic        o_datavalid,
  output logic        o_delay,
  output logic [7:0]  o_ovf_count,
  output logic        o_armed
);

  typedef enum logic [1:0] {ST_IDLE, ST_CONT, ST_SINGLE} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t         r_state;
  logic           r_mode_periodic;
  logic           r_armed;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic [7:0]     r_ovf;
  logic [31:0]    r_mem [DEPTH];

  logic           w_cmd_hit;
  logic [2:0]     w_op;
  logic           w_flush;
  logic           w_event;
  logic           w_full;
  logic           w_pop;
  logic           w_push;
  logic           w_drop;
  logic [AW:0]    w_count_nxt;
  state_t         w_state_nxt;
  logic           w_mode_nxt;

  always_comb begin
    w_cmd_hit   = i_cmden && (i_cmd[18:3] == PROBE_ID);
    w_op        = i_cmd[2:0];
    w_flush     = w_cmd_hit && (w_op == 3'd4);
    w_event     = (r_state != ST_IDLE) && (r_mode_periodic ? i_ctimer : i_probe_stb);
    w_full      = (r_count == FULL_CNT);
    w_pop       = i_ack && (r_count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the sample
    w_push      = w_event && (!w_full || w_pop);
    w_drop      = w_event && w_full && !w_pop;
    w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode_periodic;
    if (w_event && (r_state == ST_SINGLE))
      w_state_nxt = ST_IDLE;
    if (w_cmd_hit) begin
      case (w_op)
        3'd1:    w_state_nxt = ST_CONT;
        3'd2:    w_state_nxt = ST_IDLE;
        3'd3:    w_state_nxt = ST_SINGLE;
        3'd5:    w_mode_nxt  = 1'b0;
        3'd6:    w_mode_nxt  = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_uclk) begin
    if (i_urst) begin
      r_state         <= ST_IDLE;
      r_mode_periodic <= 1'b0;
      r_armed         <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_ovf           <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_mode_periodic <= w_mode_nxt;
      r_armed         <= (w_state_nxt != ST_IDLE);
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_ovf    <= '0;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= w_count_nxt;
        if (w_drop && (r_ovf != 8'hFF))
          r_ovf <= r_ovf + 8'd1;
      end
    end
  end

  always_ff @(posedge i_uclk) begin
    if (!i_urst && w_push && !w_flush)
      r_mem[r_wr_ptr] <= i_probe_in;
  end

  assign o_dataup    = (r_count != '0) ? r_mem[r_rd_ptr] : 32'd0;
  assign o_datavalid = (r_count != '0);
  assign o_delay     = w_full;
  assign o_ovf_count = r_ovf;
  assign o_armed     = r_armed;

endmodule
